pix_unpack: RTL and testbench
=============================

Name: pix_unpack

Overview:
- Single-clock successor to the framebuffer pixel-unpack and colour-map stage.
- Takes packed bus words from the framebuffer reader and splits them into pixels.
- Supports 1/2/4/8 bpp (palette-indexed), 16 bpp RGB565 and 32 bpp xRGB.
- Emits a valid/ready stream of 24-bit pixels with end-of-line marking and line clipping, ahead of the HDMI/VGA generator's pixel FIFO.

Parameters:
- DW, 32, bus word width; must be a multiple of 32.
- LGW, 12, width of the pixel-per-line counter.
- OPT_PALETTE, 1, includes the 256x24 palette RAM; when 0, indexed modes output grey: index replicated to 8 bits on all three channels.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_sync  in  1  frame-start strobe; clears the pipeline and latches mode and width
- i_mode  in  3  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp, 4=RGB565, 5=xRGB32, 6/7 illegal
- i_line_pixels  in  LGW  visible pixels per line
- i_valid  in  1  input word valid
- o_ready  out  1  input word accepted when i_valid&&o_ready
- i_data  in  DW  packed pixels, MSB first
- i_pal_we  in  1  palette write strobe
- i_pal_addr  in  8  palette write address
- i_pal_data  in  24  palette entry {R,G,B}
- o_valid  out  1  output pixel valid
- i_ready  in  1  downstream accepts pixel
- o_pixel  out  24  {R,G,B}
- o_last  out  1  last pixel of line
- o_err  out  1  sticky: illegal mode latched

Behaviour:
- Reset: o_valid=0, o_pixel=0, o_last=0, o_err=0; shift register empty, pixel count 0, latched mode=3, latched width=0. Palette contents are not reset.
- i_sync, one cycle:
  - empties the shift register and both pipeline stages (o_valid=0 next cycle);
  - clears the pixel count;
  - latches i_mode and i_line_pixels.
  - Illegal mode is latched as 3 and sets o_err. o_err clears only on reset.
  - o_ready=0 during i_sync; sync wins over a simultaneous input word.
  - Mode and width are used only as latched.
- Stage 0 (shift register): holds one DW word plus a fill count of remaining pixels.
  - On accept, fill = DW/bpp; bpp = 1,2,4,8,16,32 for modes 0..5.
  - Each advance shifts left by bpp and decrements fill.
  - The current pixel is the top bpp bits.
- o_ready is combinational: !i_sync && (fill==0 || (fill==1 && advance)). Back-to-back words stream with no bubble.
- Pipeline enable: en = !o_valid || i_ready. All stages hold when en=0.
- Stage 1: registers the index/raw pixel, a last flag and a valid flag.
- Stage 2: produces o_pixel, o_last and o_valid.
  - Palette read is synchronous, one cycle.
  - A same-cycle write to the address being read returns the old entry.
- Latency: word accepted in cycle N gives its first pixel on o_valid in cycle N+2, provided en is held high.
- Conversion:
  - Indexed: the index is zero-extended to 8 bits and used as the palette address.
  - RGB565: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
  - xRGB32: top 8 bits dropped.
- Line clipping:
  - The pixel count increments on each stage-0 advance.
  - When count == width-1 the pixel is flagged last and count returns to 0.
  - The rest of the current word is discarded: fill forced to 0.
  - The next word starts a new line.
- Width 0: words are accepted and discarded; o_valid never asserts.
- Width greater than the pixels supplied: no padding. o_last waits for data.
- Reset mid-line discards everything. Reset mid-stall drops o_valid even if i_ready=0.

Test Plan:
- Mode 3, width 8, DW=32, words 0x00010203, 0x04050607, palette[k]={k,~k,k} -> 8 pixels 00FF00, 01FE01, ..., 07F807; o_last on the 8th only; first o_valid 2 cycles after first accept.
- Mode 0, width 5, word 0xA0000000 -> pixel indices 1,0,1,0,0 with o_last on the 5th; the remaining 27 bits are dropped; the next word is accepted the cycle after.
- Mode 4, word 0xF800_07E0 -> pixels FF0000 then 00FF00; mode 5, word 0x12345678 -> 345678.
- Random i_ready at 50% with continuous i_valid, modes 0-5 -> output sequence identical to a no-stall reference model; no pixel lost or duplicated.
- i_mode=6 with i_sync -> o_err=1 and behaves as 8bpp; i_sync asserted with i_valid high -> word not accepted, o_valid=0 next cycle.
- Palette write to address 5 in the same cycle stage 1 reads index 5 -> old value output; the following read of 5 -> new value.

Source files
------------

// File: rtl/pix_unpack.sv
// Framebuffer pixel unpack and colour map: splits packed bus words into
// 1/2/4/8 bpp indexed, RGB565 or xRGB32 pixels and emits a 24-bit stream.
module pix_unpack #(
  parameter int DW          = 32,
  parameter int LGW         = 12,
  parameter bit OPT_PALETTE = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_sync,
  input  logic [2:0]     i_mode,
  input  logic [LGW-1:0] i_line_pixels,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [DW-1:0]  i_data,
  input  logic           i_pal_we,
  input  logic [7:0]     i_pal_addr,
  input  logic [23:0]    i_pal_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [23:0]    o_pixel,
  output logic           o_last,
  output logic           o_err
);

  localparam int FW = $clog2(DW) + 1;

  logic [2:0]     mode_cfg;
  logic [LGW-1:0] width_cfg;
  logic [DW-1:0]  sreg_p0;
  logic [FW-1:0]  fill_p0;
  logic [LGW-1:0] cnt_p0;
  logic           vld_p1;
  logic           last_p1;
  logic [23:0]    raw_p1;
  logic [23:0]    pal_rd_c;
  logic           en;
  logic           advance;
  logic           last_px;
  logic           accept;

  function automatic logic [5:0] bpp_of(input logic [2:0] m);
    case (m)
      3'd0:    bpp_of = 6'd1;
      3'd1:    bpp_of = 6'd2;
      3'd2:    bpp_of = 6'd4;
      3'd3:    bpp_of = 6'd8;
      3'd4:    bpp_of = 6'd16;
      default: bpp_of = 6'd32;
    endcase
  endfunction

  function automatic logic [FW-1:0] ppw_of(input logic [2:0] m);
    case (m)
      3'd0:    ppw_of = FW'(DW);
      3'd1:    ppw_of = FW'(DW / 2);
      3'd2:    ppw_of = FW'(DW / 4);
      3'd3:    ppw_of = FW'(DW / 8);
      3'd4:    ppw_of = FW'(DW / 16);
      default: ppw_of = FW'(DW / 32);
    endcase
  endfunction

  // Right-justify the top bpp bits; xRGB drops its unused top byte here.
  function automatic logic [23:0] top_pixel(input logic [31:0] top, input logic [2:0] m);
    case (m)
      3'd0:    top_pixel = {23'd0, top[31]};
      3'd1:    top_pixel = {22'd0, top[31:30]};
      3'd2:    top_pixel = {20'd0, top[31:28]};
      3'd3:    top_pixel = {16'd0, top[31:24]};
      3'd4:    top_pixel = {8'd0, top[31:16]};
      default: top_pixel = top[23:0];
    endcase
  endfunction

  function automatic logic [23:0] rgb565(input logic [15:0] p);
    rgb565 = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [23:0] grey(input logic [7:0] idx, input logic [2:0] m);
    logic [7:0] g;
    case (m)
      3'd0:    g = {8{idx[0]}};
      3'd1:    g = {4{idx[1:0]}};
      3'd2:    g = {2{idx[3:0]}};
      default: g = idx;
    endcase
    grey = {g, g, g};
  endfunction

  assign en      = !o_valid || i_ready;
  assign advance = (fill_p0 != '0) && en;
  assign last_px = (width_cfg != '0) && (cnt_p0 == width_cfg - 1'b1);
  assign o_ready = !i_sync && ((fill_p0 == '0) || ((fill_p0 == FW'(1)) && advance));
  assign accept  = i_valid && o_ready;

  // Stage 0: configuration, fill count and line position
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fill_p0   <= '0;
      cnt_p0    <= '0;
      mode_cfg  <= 3'd3;
      width_cfg <= '0;
      o_err     <= 1'b0;
    end else if (i_sync) begin
      fill_p0   <= '0;
      cnt_p0    <= '0;
      width_cfg <= i_line_pixels;
      if (i_mode > 3'd5) begin
        mode_cfg <= 3'd3;
        o_err    <= 1'b1;
      end else begin
        mode_cfg <= i_mode;
      end
    end else begin
      if (advance) begin
        // A finished line (or a zero-width line) throws away the rest of the word.
        if (last_px || (width_cfg == '0)) fill_p0 <= '0;
        else                              fill_p0 <= fill_p0 - 1'b1;
        if (last_px || (width_cfg == '0)) cnt_p0 <= '0;
        else                              cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (accept) fill_p0 <= ppw_of(mode_cfg);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept)       sreg_p0 <= i_data;
    else if (advance) sreg_p0 <= sreg_p0 << bpp_of(mode_cfg);
  end

  // Stage 1: raw pixel / palette index
  always_ff @(posedge i_clk) begin
    if (i_reset || i_sync) vld_p1 <= 1'b0;
    else if (en)           vld_p1 <= (fill_p0 != '0) && (width_cfg != '0);
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      raw_p1  <= top_pixel(sreg_p0[DW-1 -: 32], mode_cfg);
      last_p1 <= last_px;
    end
  end

  generate
    if (OPT_PALETTE) begin : g_pal
      logic [23:0] pal_mem [256];
      always_ff @(posedge i_clk) begin
        if (i_pal_we) pal_mem[i_pal_addr] <= i_pal_data;
      end
      assign pal_rd_c = pal_mem[raw_p1[7:0]];
    end else begin : g_grey
      assign pal_rd_c = grey(raw_p1[7:0], mode_cfg);
    end
  endgenerate

  // Stage 2: colour conversion / palette lookup into the output register
  always_ff @(posedge i_clk) begin
    if (i_reset || i_sync) o_valid <= 1'b0;
    else if (en)           o_valid <= vld_p1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pixel <= '0;
      o_last  <= 1'b0;
    end else if (en) begin
      o_last <= last_p1 && vld_p1;
      case (mode_cfg)
        3'd4:    o_pixel <= rgb565(raw_p1[15:0]);
        3'd5:    o_pixel <= raw_p1;
        default: o_pixel <= pal_rd_c;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_unpack.sv
// Directed and randomised-stall bench for pix_unpack with a pixel scoreboard.
module tb_pix_unpack;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_sync;
  logic [2:0]  i_mode;
  logic [11:0] i_line_pixels;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_pal_we;
  logic [7:0]  i_pal_addr;
  logic [23:0] i_pal_data;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_pixel;
  logic        o_last;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  pix_unpack #(.DW(32), .LGW(12), .OPT_PALETTE(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_mode(i_mode),
    .i_line_pixels(i_line_pixels), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
    .i_pal_data(i_pal_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_pixel(o_pixel), .o_last(o_last), .o_err(o_err)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [24:0] sb_q [$];
  logic [23:0] pal_m [256];
  logic [2:0]  m_mode;
  int          m_width;
  int          m_cnt;
  bit          stall_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the next posedge when both are high.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_pixel: observed %h last %0d expected no pixel", o_pixel, o_last);
      end
      if (sb_q.size() != 0) begin
        logic [24:0] e;
        e = sb_q.pop_front();
        chk("pixel", 32'(o_pixel), 32'(e[23:0]));
        chk("last", 32'(o_last), 32'(e[24]));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (stall_en) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
    i_pal_we = 1'b1; i_pal_addr = a; i_pal_data = d;
    tick();
    i_pal_we = 1'b0;
    pal_m[a] = d;
  endtask

  task automatic do_sync(input logic [2:0] mode, input int width, input logic with_valid);
    i_mode = mode; i_line_pixels = 12'(width); i_sync = 1'b1;
    i_valid = with_valid; i_data = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("ready_in_sync", 32'(o_ready), 32'd0);
    tick();
    i_sync = 1'b0; i_valid = 1'b0;
    sb_q.delete();
    m_mode = (mode > 3'd5) ? 3'd3 : mode;
    m_width = width;
    m_cnt = 0;
  endtask

  function automatic logic [23:0] conv(input logic [31:0] raw);
    case (m_mode)
      3'd4:    conv = {raw[15:11], raw[15:13], raw[10:5], raw[10:9], raw[4:0], raw[4:2]};
      3'd5:    conv = raw[23:0];
      default: conv = pal_m[raw[7:0]];
    endcase
  endfunction

  task automatic model_word(input logic [31:0] w);
    int bpp;
    logic [63:0] mask;
    logic [31:0] raw;
    logic last;
    if (m_width == 0) return;
    case (m_mode)
      3'd0: bpp = 1;  3'd1: bpp = 2;  3'd2: bpp = 4;
      3'd3: bpp = 8;  3'd4: bpp = 16; default: bpp = 32;
    endcase
    mask = (64'd1 << bpp) - 64'd1;
    for (int i = 0; i < 32 / bpp; i++) begin
      raw = 32'((64'(w) >> (32 - bpp * (i + 1))) & mask);
      last = (m_cnt == m_width - 1);
      sb_q.push_back({last, conv(raw)});
      if (last) begin
        m_cnt = 0;
        break;
      end
      m_cnt++;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit use_model, output int cyc);
    bit acc = 1'b0;
    cyc = 0;
    i_valid = 1'b1; i_data = w;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge i_clk);
      acc = o_ready;
      cyc++;
      tick();
    end
    i_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else if (use_model) model_word(w);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && sb_q.size() != 0; k++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int cyc;
    logic [7:0] kb;
    logic seen;
    i_reset = 1'b1; i_sync = 1'b0; i_mode = 3'd0; i_line_pixels = '0;
    i_valid = 1'b0; i_data = '0; i_pal_we = 1'b0; i_pal_addr = '0;
    i_pal_data = '0; i_ready = 1'b1;
    m_mode = 3'd3; m_width = 0; m_cnt = 0;
    tick(); tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pixel", 32'(o_pixel), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_reset = 1'b0;
    tick();
    chk("idle_ready", 32'(o_ready), 32'd1);

    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      pal_write(kb, {kb, ~kb, kb});
    end

    // 8 bpp through the palette, latency of two edges after accept
    do_sync(3'd3, 8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      kb = 8'(k);
      sb_q.push_back({(k == 7), kb, ~kb, kb});
    end
    send_word(32'h00010203, 1'b0, cyc);
    chk("lat_e0", 32'(o_valid), 32'd0);
    tick();
    chk("lat_e1", 32'(o_valid), 32'd0);
    tick();
    chk("lat_e2", 32'(o_valid), 32'd1);
    chk("lat_pix", 32'(o_pixel), 32'h0000FF00);
    send_word(32'h04050607, 1'b0, cyc);
    drain();

    // 1 bpp clipped at 5 pixels; next word accepted right after the last pixel
    do_sync(3'd0, 5, 1'b0);
    sb_q.push_back({1'b0, 24'h01FE01}); sb_q.push_back({1'b0, 24'h00FF00});
    sb_q.push_back({1'b0, 24'h01FE01}); sb_q.push_back({1'b0, 24'h00FF00});
    sb_q.push_back({1'b1, 24'h00FF00});
    for (int k = 0; k < 5; k++) sb_q.push_back({(k == 4), 24'h01FE01});
    send_word(32'hA0000000, 1'b0, cyc);
    send_word(32'hFFFFFFFF, 1'b0, cyc);
    chk("accept_gap", 32'(cyc), 32'd6);
    drain();

    // RGB565 and xRGB32 conversion
    do_sync(3'd4, 2, 1'b0);
    sb_q.push_back({1'b0, 24'hFF0000});
    sb_q.push_back({1'b1, 24'h00FF00});
    send_word(32'hF80007E0, 1'b0, cyc);
    drain();
    do_sync(3'd5, 1, 1'b0);
    sb_q.push_back({1'b1, 24'h345678});
    send_word(32'h12345678, 1'b0, cyc);
    drain();

    // Random output stalls in every mode against the no-stall model
    for (int m = 0; m < 6; m++) begin
      do_sync(3'(m), 3 + 2 * m, 1'b0);
      stall_en = 1'b1;
      for (int w = 0; w < 6; w++) send_word($urandom, 1'b1, cyc);
      drain();
      stall_en = 1'b0;
      i_ready = 1'b1;
    end

    // Sync flushes a busy pipeline; illegal mode latches as 8 bpp with o_err
    do_sync(3'd3, 4, 1'b0);
    send_word(32'h0A0B0C0D, 1'b1, cyc);
    tick(); tick();
    chk("busy_before_sync", 32'(o_valid), 32'd1);
    do_sync(3'd6, 4, 1'b1);
    chk("valid_after_sync", 32'(o_valid), 32'd0);
    chk("err_sticky", 32'(o_err), 32'd1);
    tick(); tick(); tick();
    chk("sync_word_dropped", 32'(o_valid), 32'd0);
    send_word(32'h01020304, 1'b1, cyc);
    drain();

    // Palette write colliding with the stage-2 read of the same entry
    do_sync(3'd3, 2, 1'b0);
    sb_q.push_back({1'b0, 24'h05FA05});
    sb_q.push_back({1'b1, 24'hABCDEF});
    send_word(32'h05050000, 1'b0, cyc);
    tick();
    i_pal_we = 1'b1; i_pal_addr = 8'd5; i_pal_data = 24'hABCDEF;
    tick();
    i_pal_we = 1'b0;
    pal_m[5] = 24'hABCDEF;
    drain();

    // Width 0: words accepted and discarded
    do_sync(3'd3, 0, 1'b0);
    send_word(32'h11223344, 1'b1, cyc);
    send_word(32'h55667788, 1'b1, cyc);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= o_valid;
      tick();
    end
    chk("width0_no_valid", 32'(seen), 32'd0);

    // Reset while the output is stalled
    do_sync(3'd3, 4, 1'b0);
    i_ready = 1'b0;
    send_word(32'h01020304, 1'b0, cyc);
    tick(); tick(); tick();
    chk("stalled_valid", 32'(o_valid), 32'd1);
    i_reset = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(o_valid), 32'd0);
    chk("rst_stall_err", 32'(o_err), 32'd0);
    chk("rst_stall_pixel", 32'(o_pixel), 32'd0);
    i_reset = 1'b0;
    i_ready = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", 32'(o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
